alu_serial_ctrl: RTL and testbench

Bit-serial ALU controller that sequences a WIDTH-bit operation through a single 1-bit ALU slice, one bit per clock, LSB first. It latches operands on a start handshake and owns the inter-bit carry register, bit counter and result shift register. It also performs the set-less-than fix-up at the MSB. It sits between the register file / control unit and the 1-bit slice datapath, with the slice logic implemented inside this block.

---
 rtl/alu_serial_ctrl_if.sv | 46 ++++
 rtl/alu_serial_ctrl.sv | 157 +++++++++++++++
 tb/tb_alu_serial_ctrl.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_serial_ctrl_if.sv
// ---------------------------------------------------------------------------
// alu_serial_ctrl_if
// Request/response bundle between the register file / control unit (master)
// and the bit-serial ALU controller (slave).
//   start, op[1:0], binv, a, b : request side, driven by the master
//   busy, done, result, cout   : response side, driven by the controller
//   zero                       : result == 0, combinational from result
//   overflow                   : present only when ALU_SERIAL_OVF_EN is defined
// ---------------------------------------------------------------------------
interface alu_serial_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [1:0]       op;
    logic             binv;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             zero;
`ifdef ALU_SERIAL_OVF_EN
    logic             overflow;

    modport master (
        output start, op, binv, a, b,
        input  busy, done, result, cout, zero, overflow
    );

    modport slave (
        input  start, op, binv, a, b,
        output busy, done, result, cout, zero, overflow
    );
`else
    modport master (
        output start, op, binv, a, b,
        input  busy, done, result, cout, zero
    );

    modport slave (
        input  start, op, binv, a, b,
        output busy, done, result, cout, zero
    );
`endif
endinterface

// File: rtl/alu_serial_ctrl.sv
// ---------------------------------------------------------------------------
// alu_serial_ctrl
// Bit-serial ALU controller: runs a WIDTH-bit AND / OR / ADD-SUB / SLT
// through a single 1-bit slice, one bit per clock, LSB first. Operands are
// latched on an accepted start, so the bus may change freely during RUN.
//
// Ports
//   clock : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : alu_serial_ctrl_if.slave (start/op/binv/a/b in,
//           busy/done/result/cout/zero[/overflow] out)
//
// Parameters
//   WIDTH : operand/result width in bits (>= 2)
//
// Build option
//   ALU_SERIAL_OVF_EN : adds the registered signed-overflow output (op 10).
//                       SLT uses the same internal overflow term either way.
// ---------------------------------------------------------------------------
module alu_serial_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    alu_serial_ctrl_if.slave bus
);
    localparam int              CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_ADD = 2'b10,
        OP_SLT = 2'b11
    } op_e;

    state_e           state;
    op_e              op_q;
    logic             binv_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] result_q;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             ovf_q;     // carry into MSB ^ carry out of MSB
    logic             busy_q;
    logic             done_q;
    logic             cout_q;
`ifdef ALU_SERIAL_OVF_EN
    logic             overflow_q;
`endif

    // ---------------------------------------------------------------
    // 1-bit slice for the current bit position
    // ---------------------------------------------------------------
    logic a_bit;
    logic b_eff;
    logic res_bit;
    logic carry_nxt;

    always_comb begin
        // NOTE: every output of this block is assigned before any branch,
        // so no path can leave a value unassigned and infer a latch.
        a_bit     = a_q[cnt];
        // SLT always subtracts; otherwise binv selects the inverted B.
        b_eff     = b_q[cnt] ^ ((op_q == OP_SLT) ? 1'b1 : binv_q);
        carry_nxt = (a_bit & b_eff) | (a_bit & carry) | (b_eff & carry);
        res_bit   = a_bit ^ b_eff ^ carry;
        if (op_q == OP_AND) begin
            res_bit = a_bit & b_eff;
        end else if (op_q == OP_OR) begin
            res_bit = a_bit | b_eff;
        end
    end

    // Signed less-than: sign of (a - b) corrected by the overflow term.
    logic lt;
    assign lt = sr_q[WIDTH-1] ^ ovf_q;

    // ---------------------------------------------------------------
    // Sequencer with registered outputs
    // ---------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: the operand and shift registers are reset as well, so
            // an aborted operation leaves no trace and X never reaches result.
            state      <= IDLE;
            op_q       <= OP_AND;
            binv_q     <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            sr_q       <= '0;
            result_q   <= '0;
            cnt        <= '0;
            carry      <= 1'b0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cout_q     <= 1'b0;
`ifdef ALU_SERIAL_OVF_EN
            overflow_q <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the values from before this edge, regardless of statement order.
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_q    <= bus.a;
                        b_q    <= bus.b;
                        op_q   <= op_e'(bus.op);
                        binv_q <= bus.binv;
                        cnt    <= '0;
                        // Carry-in of 1 completes the two's-complement negation.
                        carry  <= (bus.op == OP_SLT) || ((bus.op == OP_ADD) && bus.binv);
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    sr_q  <= {res_bit, sr_q[WIDTH-1:1]};
                    carry <= carry_nxt;
                    if (cnt == LAST) begin
                        ovf_q <= carry ^ carry_nxt;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    result_q <= (op_q == OP_SLT) ? {{(WIDTH-1){1'b0}}, lt} : sr_q;
                    cout_q   <= ((op_q == OP_ADD) || (op_q == OP_SLT)) ? carry : 1'b0;
`ifdef ALU_SERIAL_OVF_EN
                    overflow_q <= (op_q == OP_ADD) ? ovf_q : 1'b0;
`endif
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.cout   = cout_q;
    assign bus.zero   = (result_q == '0);
`ifdef ALU_SERIAL_OVF_EN
    assign bus.overflow = overflow_q;
`endif

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_serial_ctrl
// Self-checking bench for alu_serial_ctrl (WIDTH = 8). Expected values come
// from a word-level arithmetic model of the operations, not from the slice.
// ---------------------------------------------------------------------------
module tb_alu_serial_ctrl;
    localparam int WIDTH = 8;

    logic clock = 1'b0;
    logic reset;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    alu_serial_ctrl_if #(.WIDTH(WIDTH)) bus ();

    alu_serial_ctrl #(.WIDTH(WIDTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Word-level reference: result, carry out and signed overflow.
    function automatic void model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic [1:0] op, input logic binv,
                                  output logic [WIDTH-1:0] res, output logic cout,
                                  output logic ovf);
        logic [WIDTH-1:0] eb;
        longint           u;
        int               sa, sb, seb, full;
        eb   = binv ? ~b : b;
        sa   = $signed(a);
        sb   = $signed(b);
        seb  = $signed(eb);
        res  = '0;
        cout = 1'b0;
        ovf  = 1'b0;
        case (op)
            2'b00: res = a & eb;
            2'b01: res = a | eb;
            2'b10: begin
                u    = longint'(a) + longint'(eb) + longint'(binv);
                res  = WIDTH'(u);
                cout = (u >= (longint'(1) << WIDTH));
                full = sa + seb + int'(binv);
                ovf  = (full > (2 ** (WIDTH - 1)) - 1) || (full < -(2 ** (WIDTH - 1)));
            end
            default: begin
                res  = (sa < sb) ? WIDTH'(1) : '0;
                cout = (a >= b);
            end
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] pick_val();
        logic [WIDTH-1:0] edges [4];
        edges[0] = '0;
        edges[1] = {1'b0, {(WIDTH-1){1'b1}}};
        edges[2] = {1'b1, {(WIDTH-1){1'b0}}};
        edges[3] = '1;
        if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 3)];
        return WIDTH'($urandom);
    endfunction

    // One operation with full cycle-by-cycle handshake checks. With noise set,
    // extra start pulses are issued during RUN and DONE. Operands on the bus
    // are scrambled right after acceptance in every case.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [1:0] op, input logic binv, input logic noise,
                          input string name, output logic [WIDTH-1:0] got);
        logic [WIDTH-1:0] er;
        logic             ec, eo;
        model(a, b, op, binv, er, ec, eo);
        bus.a = a; bus.b = b; bus.op = op; bus.binv = binv; bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        bus.a = WIDTH'($urandom);
        bus.b = WIDTH'($urandom);
        bus.op = 2'($urandom);
        for (int i = 0; i <= WIDTH; i++) begin
            if (i > 0) begin
                @(posedge clock); #1;
            end
            total_cnt++;
            if ({bus.busy, bus.done} !== 2'b10)
                $display("FAIL %s busy/done at cycle %0d: got %b%b want 10", name, i, bus.busy, bus.done);
            else pass_cnt++;
            bus.start = noise && (i == 3 || i == WIDTH);
        end
        @(posedge clock); #1;
        bus.start = 1'b0;
        got = bus.result;
        total_cnt++;
        if ({bus.busy, bus.done} !== 2'b01)
            $display("FAIL %s done edge busy/done: got %b%b want 01", name, bus.busy, bus.done);
        else pass_cnt++;
        total_cnt++;
        if (bus.result !== er) $display("FAIL %s result: got %h want %h", name, bus.result, er);
        else pass_cnt++;
        total_cnt++;
        if (bus.cout !== ec) $display("FAIL %s cout: got %b want %b", name, bus.cout, ec);
        else pass_cnt++;
        total_cnt++;
        if (bus.zero !== (er == '0)) $display("FAIL %s zero: got %b want %b", name, bus.zero, er == '0);
        else pass_cnt++;
`ifdef ALU_SERIAL_OVF_EN
        total_cnt++;
        if (bus.overflow !== eo) $display("FAIL %s overflow: got %b want %b", name, bus.overflow, eo);
        else pass_cnt++;
`endif
        @(posedge clock); #1;
        total_cnt++;
        if ({bus.busy, bus.done} !== 2'b00)
            $display("FAIL %s after done busy/done: got %b%b want 00", name, bus.busy, bus.done);
        else pass_cnt++;
        total_cnt++;
        if (bus.result !== er) $display("FAIL %s result hold: got %h want %h", name, bus.result, er);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        total_cnt++;
        if ({bus.result, bus.zero, bus.busy, bus.done, bus.cout} !== {{WIDTH{1'b0}}, 4'b1000})
            $display("FAIL reset outputs: got result=%h zero=%b busy=%b done=%b cout=%b want 00 1 0 0 0",
                     bus.result, bus.zero, bus.busy, bus.done, bus.cout);
        else pass_cnt++;
`ifdef ALU_SERIAL_OVF_EN
        total_cnt++;
        if (bus.overflow !== 1'b0) $display("FAIL reset overflow: got %b want 0", bus.overflow);
        else pass_cnt++;
`endif
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_directed();
        logic [WIDTH-1:0] got;
        logic [WIDTH-1:0] av [8];
        logic [WIDTH-1:0] bv [8];
        logic [WIDTH-1:0] want [8];
        logic [1:0]       ov [8];
        logic             iv [8];
        av = '{8'h7F, 8'h05, 8'h07, 8'hFD, 8'h02, 8'h7F, 8'hF0, 8'hF0};
        bv = '{8'h01, 8'h07, 8'h07, 8'h02, 8'hFD, 8'h80, 8'h3C, 8'h3C};
        ov = '{2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b11, 2'b00, 2'b01};
        iv = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b0,  1'b1,  1'b0};
        want = '{8'h80, 8'hFE, 8'h00, 8'h01, 8'h00, 8'h00, 8'hC0, 8'hFC};
        for (int i = 0; i < 8; i++) begin
            run_op(av[i], bv[i], ov[i], iv[i], 1'b0, $sformatf("directed%0d", i), got);
            total_cnt++;
            if (got !== want[i]) $display("FAIL directed%0d literal: got %h want %h", i, got, want[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] got;
        for (int i = 0; i < 40; i++)
            run_op(pick_val(), pick_val(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   1'b0, $sformatf("random%0d", i), got);
    endtask

    task automatic test_ignore_start();
        logic [WIDTH-1:0] got;
        for (int i = 0; i < 6; i++)
            run_op(pick_val(), pick_val(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   1'b1, $sformatf("noisy%0d", i), got);
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] av [4];
        logic [WIDTH-1:0] bv [4];
        logic [1:0]       ov [4];
        logic             iv [4];
        logic [WIDTH-1:0] er;
        logic             ec, eo;
        int               n;
        for (int i = 0; i < 4; i++) begin
            av[i] = pick_val(); bv[i] = pick_val();
            ov[i] = 2'($urandom_range(0, 3)); iv[i] = 1'($urandom_range(0, 1));
        end
        n = 0;
        bus.a = av[0]; bus.b = bv[0]; bus.op = ov[0]; bus.binv = iv[0]; bus.start = 1'b1;
        @(posedge clock); #1;
        for (int c = 1; c < 4 * (WIDTH + 2); c++) begin
            @(posedge clock); #1;
            if (bus.done) begin
                total_cnt++;
                if (c != (WIDTH + 1) + n * (WIDTH + 2))
                    $display("FAIL b2b done timing: got cycle %0d want %0d", c, (WIDTH + 1) + n * (WIDTH + 2));
                else pass_cnt++;
                if (n < 4) begin
                    model(av[n], bv[n], ov[n], iv[n], er, ec, eo);
                    total_cnt++;
                    if (bus.result !== er) $display("FAIL b2b%0d result: got %h want %h", n, bus.result, er);
                    else pass_cnt++;
                end
                n++;
                if (n < 4) begin
                    bus.a = av[n]; bus.b = bv[n]; bus.op = ov[n]; bus.binv = iv[n];
                end else begin
                    bus.start = 1'b0;
                end
            end
        end
        bus.start = 1'b0;
        total_cnt++;
        if (n != 4) $display("FAIL b2b done count: got %0d want 4", n);
        else pass_cnt++;
        repeat (WIDTH + 3) @(posedge clock);
        #1;
    endtask

    task automatic test_mid_reset();
        logic [WIDTH-1:0] got;
        int               seen;
        run_op(8'hFF, 8'h02, 2'b10, 1'b0, 1'b0, "pre_reset_add", got);
        bus.a = 8'h55; bus.b = 8'h0F; bus.op = 2'b10; bus.binv = 1'b0; bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        total_cnt++;
        if ({bus.result, bus.zero, bus.busy, bus.done, bus.cout} !== {{WIDTH{1'b0}}, 4'b1000})
            $display("FAIL mid-run reset outputs: got result=%h zero=%b busy=%b done=%b cout=%b want 00 1 0 0 0",
                     bus.result, bus.zero, bus.busy, bus.done, bus.cout);
        else pass_cnt++;
        @(posedge clock); #1;
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < WIDTH + 4; i++) begin
            @(posedge clock); #1;
            if (bus.done || bus.busy) seen++;
        end
        total_cnt++;
        if (seen != 0) $display("FAIL mid-run reset activity: got %0d busy/done cycles want 0", seen);
        else pass_cnt++;
        run_op(8'h12, 8'h34, 2'b10, 1'b0, 1'b0, "post_reset_add", got);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.binv  = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        reset     = 1'b1;
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
